cram_load_seq: RTL and testbench

- Diagnostic microcode loader/verifier for the 2K-word CRAM.
- Accepts 28-bit chunks from the diagnostic EBUS path over a valid/ready handshake and assembles each 84-bit CRAM word from three chunks.
- In load mode, writes each assembled word to sequential CRAM addresses; in verify mode, reads each word back and compares it.
- Holds the EBOX microcode clock stopped while busy, so CRADR sequencing never overlaps a load.

---
 rtl/cram_load_seq.sv | 179 +++++++++++++++++
 tb/tb_cram_load_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_load_seq.sv
// Diagnostic CRAM loader/verifier: assembles three EBUS chunks into one CRAM word,
// then writes it or reads it back and compares, holding the EBOX clock while busy.
module cram_load_seq #(
    parameter int ADR_W   = 11,
    parameter int DATA_W  = 84,
    parameter int CHUNK_W = 28
) (
    input  logic              eboxClk,
    input  logic              eboxResetN,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [ADR_W-1:0]  startAdr,
    input  logic [ADR_W:0]    wordCount,
    input  logic              dataValid,
    input  logic [0:35]       dataIn,
    output logic              dataReady,
    output logic [ADR_W-1:0]  cramAdr,
    output logic [DATA_W-1:0] cramWrData,
    output logic              cramWrEn,
    output logic              cramRdEn,
    input  logic [DATA_W-1:0] cramRdData,
    output logic              clkHold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADR_W-1:0]  errAdr,
    output logic [ADR_W:0]    wordsDone
);

    typedef enum logic [2:0] {
        S_IDLE, S_CH0, S_CH1, S_CH2, S_WRITE, S_READ, S_CHECK, S_DONE
    } state_t;

    localparam logic [ADR_W+1:0] CRAM_WORDS = {2'b01, {ADR_W{1'b0}}};

    state_t              state_q, state_d;
    logic                verify_q, verify_d;
    logic [ADR_W:0]      count_q, count_d;
    logic [ADR_W-1:0]    adr_d, err_adr_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic                error_d;
    logic [ADR_W:0]      words_d, words_inc;
    logic [ADR_W+1:0]    end_sum;
    logic [CHUNK_W-1:0]  chunk;
    logic                xfer;
    logic                unused_hi;

    assign chunk     = dataIn[36-CHUNK_W:35];
    assign unused_hi = ^dataIn[0:35-CHUNK_W];
    assign words_inc = wordsDone + 1'b1;
    assign end_sum   = {2'b00, startAdr} + {1'b0, wordCount};
    assign busy      = (state_q != S_IDLE);
    assign clkHold   = busy;

    always_comb begin
        state_d    = state_q;
        verify_d   = verify_q;
        count_d    = count_q;
        adr_d      = cramAdr;
        wr_data_d  = cramWrData;
        error_d    = error;
        err_adr_d  = errAdr;
        words_d    = wordsDone;
        dataReady  = 1'b0;
        cramWrEn   = 1'b0;
        cramRdEn   = 1'b0;
        done       = 1'b0;
        xfer       = 1'b0;

        // abort freezes every register except the state, and suppresses all strobes
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        verify_d  = verify;
                        count_d   = wordCount;
                        adr_d     = startAdr;
                        error_d   = 1'b0;
                        err_adr_d = '0;
                        words_d   = '0;
                        if (wordCount == '0) begin
                            state_d = S_DONE;
                        end else if (end_sum > CRAM_WORDS) begin
                            error_d   = 1'b1;
                            err_adr_d = startAdr;
                            state_d   = S_DONE;
                        end else begin
                            state_d = S_CH0;
                        end
                    end
                end
                S_CH0: begin
                    dataReady = 1'b1;
                    xfer      = dataValid;
                    if (xfer) begin
                        wr_data_d[DATA_W-1 -: CHUNK_W] = chunk;
                        state_d = S_CH1;
                    end
                end
                S_CH1: begin
                    dataReady = 1'b1;
                    xfer      = dataValid;
                    if (xfer) begin
                        wr_data_d[DATA_W-CHUNK_W-1 -: CHUNK_W] = chunk;
                        state_d = S_CH2;
                    end
                end
                S_CH2: begin
                    dataReady = 1'b1;
                    xfer      = dataValid;
                    if (xfer) begin
                        wr_data_d[CHUNK_W-1:0] = chunk;
                        state_d = verify_q ? S_READ : S_WRITE;
                    end
                end
                S_WRITE: begin
                    cramWrEn = 1'b1;
                    words_d  = words_inc;
                    if (words_inc == count_q) begin
                        state_d = S_DONE;
                    end else begin
                        adr_d   = cramAdr + ADR_W'(1);
                        state_d = S_CH0;
                    end
                end
                S_READ: begin
                    cramRdEn = 1'b1;
                    state_d  = S_CHECK;
                end
                S_CHECK: begin
                    if (cramRdData != cramWrData) begin
                        error_d   = 1'b1;
                        err_adr_d = cramAdr;
                        state_d   = S_DONE;
                    end else begin
                        words_d = words_inc;
                        if (words_inc == count_q) begin
                            state_d = S_DONE;
                        end else begin
                            adr_d   = cramAdr + ADR_W'(1);
                            state_d = S_CH0;
                        end
                    end
                end
                S_DONE: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge eboxClk or negedge eboxResetN) begin
        if (!eboxResetN) begin
            state_q    <= S_IDLE;
            verify_q   <= 1'b0;
            count_q    <= '0;
            cramAdr    <= '0;
            cramWrData <= '0;
            error      <= 1'b0;
            errAdr     <= '0;
            wordsDone  <= '0;
        end else begin
            state_q    <= state_d;
            verify_q   <= verify_d;
            count_q    <= count_d;
            cramAdr    <= adr_d;
            cramWrData <= wr_data_d;
            error      <= error_d;
            errAdr     <= err_adr_d;
            wordsDone  <= words_d;
        end
    end

endmodule

// File: tb/tb_cram_load_seq.sv
// Directed bench for cram_load_seq: expected CRAM writes go through a scoreboard
// queue that a negedge monitor drains and checks.
`timescale 1ns/1ps
module tb_cram_load_seq;

    logic         eboxClk = 1'b0;
    logic         eboxResetN;
    logic         start, verify, abort;
    logic [10:0]  startAdr;
    logic [11:0]  wordCount;
    logic         dataValid;
    logic [0:35]  dataIn;
    logic         dataReady;
    logic [10:0]  cramAdr;
    logic [83:0]  cramWrData;
    logic         cramWrEn, cramRdEn;
    logic [83:0]  cramRdData;
    logic         clkHold, busy, done, error;
    logic [10:0]  errAdr;
    logic [11:0]  wordsDone;

    typedef struct {
        logic [10:0] adr;
        logic [83:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [83:0] stub_word;
    int          n_cmp = 0, n_bad = 0;
    int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, acc_cnt = 0;
    int          wr0, rd0, dn0, acc0;

    cram_load_seq #(.ADR_W(11), .DATA_W(84), .CHUNK_W(28)) dut (
        .eboxClk(eboxClk), .eboxResetN(eboxResetN), .start(start), .verify(verify),
        .abort(abort), .startAdr(startAdr), .wordCount(wordCount),
        .dataValid(dataValid), .dataIn(dataIn), .dataReady(dataReady),
        .cramAdr(cramAdr), .cramWrData(cramWrData), .cramWrEn(cramWrEn),
        .cramRdEn(cramRdEn), .cramRdData(cramRdData), .clkHold(clkHold),
        .busy(busy), .done(done), .error(error), .errAdr(errAdr), .wordsDone(wordsDone)
    );

    always #5 eboxClk = ~eboxClk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CRAM read stub: data returned the cycle after the read strobe
    always @(posedge eboxClk) if (cramRdEn) cramRdData <= stub_word;
    always @(posedge eboxClk) if (eboxResetN && dataValid && dataReady) acc_cnt++;

    always @(negedge eboxClk) begin
        if (eboxResetN) begin
            if (cramWrEn) begin
                wr_cnt++;
                chk("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_adr", cramAdr, e.adr);
                    chk("wr_data", cramWrData, e.data);
                end
            end
            if (cramRdEn) rd_cnt++;
            if (cramWrEn || cramRdEn) chk("strobe_excl", cramWrEn && cramRdEn, 0);
            if (done) done_cnt++;
        end
    end

    task automatic push_wr(input logic [10:0] a, input logic [27:0] c0, c1, c2);
        wr_t e;
        e.adr  = a;
        e.data = {c0, c1, c2};
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic v, input logic [10:0] a, input logic [11:0] n);
        @(negedge eboxClk);
        start = 1'b1; verify = v; startAdr = a; wordCount = n;
        @(negedge eboxClk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [27:0] c, input bit rnd);
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge eboxClk);
            if (rnd && ($urandom_range(0, 2) == 0)) begin
                dataValid = 1'b0; dataIn = '0;
            end else begin
                dataValid = 1'b1; dataIn = {8'h00, c};
            end
            if (dataValid && dataReady) begin
                ok = 1;
                break;
            end
        end
        chk("chunk_accepted", ok, 1);
    endtask

    task automatic bus_idle();
        @(negedge eboxClk);
        dataValid = 1'b0;
        dataIn    = '0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 500; k++) begin
            if (k != 0) @(negedge eboxClk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic snap();
        wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; acc0 = acc_cnt;
    endtask

    initial begin
        logic [27:0] rc[9];

        eboxResetN = 1'b0; start = 0; verify = 0; abort = 0;
        startAdr = '0; wordCount = '0; dataValid = 0; dataIn = '0; stub_word = '0;
        cramRdData = '0;
        repeat (3) @(negedge eboxClk);
        chk("rst_busy", busy, 0);
        chk("rst_clkHold", clkHold, 0);
        chk("rst_dataReady", dataReady, 0);
        chk("rst_cramAdr", cramAdr, 0);
        chk("rst_cramWrData", cramWrData, 0);
        chk("rst_wordsDone", wordsDone, 0);
        chk("rst_error", error, 0);
        chk("rst_errAdr", errAdr, 0);
        eboxResetN = 1'b1;

        // two-word load at 0x100
        snap();
        push_wr(11'h100, 28'hAAAAAAA, 28'h5555555, 28'h1234567);
        push_wr(11'h101, 28'h0000001, 28'h0000002, 28'h0000003);
        do_start(0, 11'h100, 12'd2);
        feed(28'hAAAAAAA, 0); feed(28'h5555555, 0); feed(28'h1234567, 0);
        feed(28'h0000001, 0); feed(28'h0000002, 0); feed(28'h0000003, 0);
        bus_idle();
        wait_done();
        chk("load2_busy_in_done", busy, 1);
        chk("load2_wordsDone", wordsDone, 2);
        chk("load2_error", error, 0);
        @(negedge eboxClk); #1;
        chk("load2_idle", busy, 0);
        chk("load2_writes", wr_cnt - wr0, 2);
        chk("load2_sb_drained", exp_q.size(), 0);

        // range overflow: no CRAM access, done one cycle after start
        snap();
        do_start(0, 11'h7FF, 12'd2);
        chk("range_done_timing", done, 1);
        chk("range_error", error, 1);
        chk("range_errAdr", errAdr, 11'h7FF);
        @(negedge eboxClk); #1;
        chk("range_done_once", done_cnt - dn0, 1);
        chk("range_strobes", (wr_cnt - wr0) + (rd_cnt - rd0), 0);

        // verify with a single-bit miscompare
        snap();
        stub_word = {28'h1111111, 28'h2222222, 28'h3333333} ^ 84'h1;
        do_start(1, 11'h010, 12'd1);
        feed(28'h1111111, 0); feed(28'h2222222, 0); feed(28'h3333333, 0);
        bus_idle();
        wait_done();
        chk("vfy_err_error", error, 1);
        chk("vfy_err_errAdr", errAdr, 11'h010);
        chk("vfy_err_wordsDone", wordsDone, 0);
        @(negedge eboxClk); #1;
        chk("vfy_err_reads", rd_cnt - rd0, 1);
        chk("vfy_err_writes", wr_cnt - wr0, 0);
        chk("vfy_err_done", done_cnt - dn0, 1);

        // verify with matching data clears the previous error
        stub_word = {28'h0ABCDEF, 28'h0FEDCBA, 28'h7654321};
        do_start(1, 11'h011, 12'd1);
        feed(28'h0ABCDEF, 0); feed(28'h0FEDCBA, 0); feed(28'h7654321, 0);
        bus_idle();
        wait_done();
        chk("vfy_ok_error", error, 0);
        chk("vfy_ok_wordsDone", wordsDone, 1);

        // three-word load with random valid stalls
        snap();
        for (int i = 0; i < 9; i++) rc[i] = 28'($urandom);
        for (int w = 0; w < 3; w++) push_wr(11'h400 + 11'(w), rc[3*w], rc[3*w+1], rc[3*w+2]);
        do_start(0, 11'h400, 12'd3);
        for (int i = 0; i < 9; i++) feed(rc[i], 1);
        bus_idle();
        wait_done();
        chk("hs_wordsDone", wordsDone, 3);
        @(negedge eboxClk); #1;
        chk("hs_chunks", acc_cnt - acc0, 9);
        chk("hs_writes", wr_cnt - wr0, 3);
        chk("hs_sb_drained", exp_q.size(), 0);

        // abort in CH2 of word 2, then restart
        snap();
        push_wr(11'h200, 28'h0000011, 28'h0000022, 28'h0000033);
        do_start(0, 11'h200, 12'd4);
        feed(28'h0000011, 0); feed(28'h0000022, 0); feed(28'h0000033, 0);
        feed(28'h0000044, 0); feed(28'h0000055, 0);
        @(negedge eboxClk);
        dataValid = 1'b0; dataIn = '0; abort = 1'b1;
        @(negedge eboxClk);
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_wordsDone", wordsDone, 1);
        chk("abort_error", error, 0);
        repeat (10) @(negedge eboxClk);
        #1;
        chk("abort_writes", wr_cnt - wr0, 1);
        chk("abort_no_done", done_cnt - dn0, 0);
        push_wr(11'h300, 28'h0C0FFEE, 28'h0BEEF00, 28'h0123ABC);
        do_start(0, 11'h300, 12'd1);
        feed(28'h0C0FFEE, 0); feed(28'h0BEEF00, 0); feed(28'h0123ABC, 0);
        bus_idle();
        wait_done();
        chk("restart_wordsDone", wordsDone, 1);
        @(negedge eboxClk); #1;
        chk("restart_sb_drained", exp_q.size(), 0);

        // async reset while in WRITE
        do_start(0, 11'h050, 12'd1);
        feed(28'h1010101, 0); feed(28'h2020202, 0); feed(28'h3030303, 0);
        @(posedge eboxClk); #2;
        dataValid = 1'b0; dataIn = '0;
        chk("pre_rst_in_write", cramWrEn, 1);
        #1 eboxResetN = 1'b0;
        #1;
        chk("arst_wrEn", cramWrEn, 0);
        chk("arst_busy", busy, 0);
        chk("arst_clkHold", clkHold, 0);
        chk("arst_cramAdr", cramAdr, 0);
        chk("arst_cramWrData", cramWrData, 0);
        chk("arst_wordsDone", wordsDone, 0);
        @(negedge eboxClk);
        eboxResetN = 1'b1;

        // zero-length request
        snap();
        do_start(0, 11'h020, 12'd0);
        chk("zero_done_timing", done, 1);
        chk("zero_error", error, 0);
        @(negedge eboxClk); #1;
        chk("zero_strobes", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
        chk("zero_done_once", done_cnt - dn0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
